// File: rtl/dir_pkg.sv
// Shared direction definitions for the button conditioner and the position tracker.
// Bit indices of the direction bus and the per-channel auto-repeat state encoding.
package dir_pkg;

    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_LEFT  = 2;
    localparam int unsigned DIR_RIGHT = 3;
    localparam int unsigned NUM_DIRS  = 4;

    typedef enum logic [1:0] {
        StOff,
        StHold,
        StGap,
        StRpt
    } rpt_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, stable-sample debounce counter and a
// hold-to-repeat FSM that punches one-cycle low gaps into a held press.
module debounce_chan
    import dir_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 20000,
    parameter int unsigned HOLD_CYCLES   = 500000,
    parameter int unsigned REPEAT_CYCLES = 100000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic dir_o,
    output logic held_o
);

    localparam int unsigned CntW   = $clog2(DB_CYCLES);
    localparam int unsigned TmrMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TmrW   = $clog2(TmrMax);

    localparam logic [CntW-1:0] CntLast  = CntW'(DB_CYCLES - 1);
    localparam logic [TmrW-1:0] HoldLast = TmrW'(HOLD_CYCLES - 1);
    localparam logic [TmrW-1:0] RptLast  = TmrW'(REPEAT_CYCLES - 1);
    localparam logic [TmrW-1:0] TmrSat   = '1;

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            deb_q, deb_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    rpt_state_e      state_q, state_d;
    logic            dir_q, dir_d;
    logic            s;

    assign sync_d = {sync_q[0], btn_raw_i};
    assign s      = sync_q[1];

    // Any agreeing sample restarts the count; only an unbroken run flips the level.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (s == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            deb_d = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = (tmr_q == TmrSat) ? tmr_q : tmr_q + 1'b1;
        unique case (state_q)
            StOff: begin
                if (deb_q) begin
                    state_d = StHold;
                    tmr_d   = '0;
                end
            end
            StHold: begin
                if (REPEAT_EN && (tmr_q == HoldLast)) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StRpt;
                tmr_d   = '0;
            end
            StRpt: begin
                if (tmr_q == RptLast) begin
                    state_d = StGap;
                end
            end
            default: state_d = StOff;
        endcase
        // A release wins over any timer expiry in the same cycle.
        if (!deb_q) begin
            state_d = StOff;
        end
        dir_d = (state_d == StHold) || (state_d == StRpt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            tmr_q   <= '0;
            state_q <= StOff;
            dir_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            tmr_q   <= tmr_d;
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    assign dir_o  = dir_q;
    assign held_o = deb_q;

endmodule

// File: rtl/dir_debounce.sv
// Four independent direction-button conditioners feeding the position tracker's
// dir_udlr input; bit order follows the shared direction indices.
module dir_debounce
    import dir_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 20000,
    parameter int unsigned HOLD_CYCLES   = 500000,
    parameter int unsigned REPEAT_CYCLES = 100000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_DIRS-1:0] btn_raw,
    output logic [NUM_DIRS-1:0] dir_udlr,
    output logic [NUM_DIRS-1:0] held
);

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_chan
        debounce_chan #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw_i (btn_raw[i]),
            .dir_o     (dir_udlr[i]),
            .held_o    (held[i])
        );
    end

endmodule
